// File: rtl/qspi_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qspi_ram_pkg
// Brief    : Shared states, command codes and widths for the QSPI RAM responder
// Revision : 1.0 - initial release
// ============================================================================
package qspi_ram_pkg;

    localparam int BUS_ADDR_W   = 24;
    localparam int NIB_W        = 4;
    localparam int BYTE_W       = 8;
    localparam int ADDR_NIBBLES = 6;

    localparam logic [BYTE_W-1:0] CMD_READ  = 8'hEB;
    localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h38;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_RDATA  = 3'd4,
        ST_WDATA  = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/qspi_ram_store.sv
`default_nettype none
// ============================================================================
// Module   : qspi_ram_store
// Brief    : Single-port synchronous byte RAM, 1-cycle read latency, no reset
// Revision : 1.0 - initial release
// ============================================================================
module qspi_ram_store #(
    parameter int ADDR_W = 12
) (
    input  logic              clock,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    input  logic              we,
    output logic [7:0]        rdata
);

    logic [7:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        rdata <= r_mem[addr];
    end

endmodule
`default_nettype wire

// File: rtl/qspi_ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : qspi_ram_responder
// Brief    : Oversampling QPI PSRAM responder serving quad read/write bursts
//            from an internal byte store. Define QSPI_RAM_RESPONDER_SPI_CMD_EN
//            to receive the command byte serially on io0.
// Revision : 1.0 - initial release
// ============================================================================
module qspi_ram_responder
    import qspi_ram_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DUMMY  = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ram_clk,
    input  logic       ram_csn,
    input  logic [3:0] ram_io_i,
    output logic [3:0] ram_io_o,
    output logic       ram_io_oe,
    output logic       busy
);

    logic [2:0]        r_clk_s;
    logic [2:0]        r_csn_s;
    logic [3:0]        r_io_s0;
    logic [3:0]        r_io_s1;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_is_read;
    logic              r_nib_hi;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_rd_lo;
    logic [3:0]        r_wr_hi;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;
    logic              r_mem_we;
    logic [7:0]        w_rdata;

`ifdef QSPI_RAM_RESPONDER_SPI_CMD_EN
    localparam int         c_CMD_KEEP  = 7;
    localparam logic [3:0] c_CMD_RISES = 4'd8;
    logic [c_CMD_KEEP-1:0] r_cmd;
    logic [7:0]            w_cmd_next;
    assign w_cmd_next = {r_cmd, r_io_s1[0]};
`else
    localparam int         c_CMD_KEEP  = 4;
    localparam logic [3:0] c_CMD_RISES = 4'd2;
    logic [c_CMD_KEEP-1:0] r_cmd;
    logic [7:0]            w_cmd_next;
    assign w_cmd_next = {r_cmd, r_io_s1};
`endif

    localparam logic [3:0] c_ADDR_LAST  = 4'(ADDR_NIBBLES - 1);
    localparam logic [3:0] c_DUMMY_LAST = 4'(DUMMY - 1);

    logic              w_rise;
    logic              w_fall;
    logic              w_csn;
    logic              w_csn_fall;
    logic [ADDR_W-1:0] w_addr_next;
    logic [ADDR_W-1:0] w_addr_inc;

    assign w_rise      = r_clk_s[1] & ~r_clk_s[2];
    assign w_fall      = ~r_clk_s[1] & r_clk_s[2];
    assign w_csn       = r_csn_s[1];
    assign w_csn_fall  = ~r_csn_s[1] & r_csn_s[2];
    // Only the low ADDR_W bits of the 24-bit bus address survive the shift
    assign w_addr_next = {r_addr[ADDR_W-5:0], r_io_s1};
    assign w_addr_inc  = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign busy        = (r_state != ST_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_clk_s <= 3'b000;
            r_csn_s <= 3'b111;
            r_io_s0 <= 4'h0;
            r_io_s1 <= 4'h0;
        end else begin
            r_clk_s <= {r_clk_s[1:0], ram_clk};
            r_csn_s <= {r_csn_s[1:0], ram_csn};
            r_io_s0 <= ram_io_i;
            r_io_s1 <= r_io_s0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_cmd       <= '0;
            r_is_read   <= 1'b0;
            r_nib_hi    <= 1'b0;
            r_addr      <= '0;
            r_rd_lo     <= 4'h0;
            r_wr_hi     <= 4'h0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'h00;
            r_mem_we    <= 1'b0;
            ram_io_o    <= 4'h0;
            ram_io_oe   <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            // Deselect outranks any coincident ram_clk edge
            if (r_state != ST_IDLE && w_csn) begin
                r_state   <= ST_IDLE;
                r_cnt     <= 4'd0;
                ram_io_oe <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_csn_fall) begin
                            r_state <= ST_CMD;
                            r_cnt   <= 4'd0;
                        end
                    end
                    ST_CMD: begin
                        if (w_rise) begin
                            r_cmd <= w_cmd_next[c_CMD_KEEP-1:0];
                            if (r_cnt == c_CMD_RISES - 4'd1) begin
                                r_cnt <= 4'd0;
                                if (w_cmd_next == CMD_READ) begin
                                    r_is_read <= 1'b1;
                                    r_state   <= ST_ADDR;
                                end else if (w_cmd_next == CMD_WRITE) begin
                                    r_is_read <= 1'b0;
                                    r_state   <= ST_ADDR;
                                end else begin
                                    r_state <= ST_IGNORE;
                                end
                            end else begin
                                r_cnt <= r_cnt + 4'd1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (w_rise) begin
                            r_addr <= w_addr_next;
                            if (r_cnt == c_ADDR_LAST) begin
                                r_cnt    <= 4'd0;
                                r_nib_hi <= 1'b1;
                                if (r_is_read) begin
                                    r_mem_addr <= w_addr_next;
                                    r_state    <= ST_DUMMY;
                                end else begin
                                    r_state <= ST_WDATA;
                                end
                            end else begin
                                r_cnt <= r_cnt + 4'd1;
                            end
                        end
                    end
                    ST_DUMMY: begin
                        if (w_rise) begin
                            if (r_cnt == c_DUMMY_LAST) begin
                                r_cnt   <= 4'd0;
                                r_state <= ST_RDATA;
                            end else begin
                                r_cnt <= r_cnt + 4'd1;
                            end
                        end
                    end
                    ST_RDATA: begin
                        // High-nibble fall captures the byte and prefetches the next one
                        if (w_fall) begin
                            ram_io_oe <= 1'b1;
                            r_nib_hi  <= ~r_nib_hi;
                            if (r_nib_hi) begin
                                ram_io_o   <= w_rdata[7:4];
                                r_rd_lo    <= w_rdata[3:0];
                                r_mem_addr <= w_addr_inc;
                                r_addr     <= w_addr_inc;
                            end else begin
                                ram_io_o <= r_rd_lo;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (w_rise) begin
                            r_nib_hi <= ~r_nib_hi;
                            if (r_nib_hi) begin
                                r_wr_hi <= r_io_s1;
                            end else begin
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= r_addr;
                                r_mem_wdata <= {r_wr_hi, r_io_s1};
                                r_addr      <= w_addr_inc;
                            end
                        end
                    end
                    ST_IGNORE: begin
                        r_cnt <= 4'd0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    qspi_ram_store #(
        .ADDR_W (ADDR_W)
    ) u_store (
        .clock (clock),
        .addr  (r_mem_addr),
        .wdata (r_mem_wdata),
        .we    (r_mem_we),
        .rdata (w_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_qspi_ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_qspi_ram_responder
// Brief    : Self-checking bench: vector table, corner sequences, random bursts
// Revision : 1.0 - initial release
// ============================================================================
module tb_qspi_ram_responder;

    localparam int ADDR_W = 12;
    localparam int DUMMY  = 2;
    localparam int HALF   = 50;
    localparam int DEPTH  = 1 << ADDR_W;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ram_clk = 1'b0;
    logic       ram_csn = 1'b1;
    logic [3:0] ram_io_i = 4'h0;
    logic [3:0] ram_io_o;
    logic       ram_io_oe;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] model [0:DEPTH-1];
    logic [7:0] rd_buf [0:7];

    typedef struct {
        bit          wr;
        logic [23:0] addr;
        int          len;
        logic [31:0] bytes;
    } vec_t;

    vec_t vecs [6];

    qspi_ram_responder #(
        .ADDR_W (ADDR_W),
        .DUMMY  (DUMMY)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ram_clk   (ram_clk),
        .ram_csn   (ram_csn),
        .ram_io_i  (ram_io_i),
        .ram_io_o  (ram_io_o),
        .ram_io_oe (ram_io_oe),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic [3:0] n, output logic [3:0] s, output logic o);
        ram_io_i = n;
        #(HALF);
        s = ram_io_o;
        o = ram_io_oe;
        ram_clk = 1'b1;
        #(HALF);
        ram_clk = 1'b0;
    endtask

    task automatic csn_low();
        ram_csn = 1'b0;
        #(2*HALF);
    endtask

    task automatic csn_high();
        #(HALF);
        ram_csn = 1'b1;
        #200;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        logic [3:0] s;
        logic       o;
`ifdef QSPI_RAM_RESPONDER_SPI_CMD_EN
        for (int i = 7; i >= 0; i--) cycle({3'b110, c[i]}, s, o);
`else
        cycle(c[7:4], s, o);
        cycle(c[3:0], s, o);
`endif
    endtask

    task automatic send_addr(input logic [23:0] a);
        logic [3:0] s;
        logic       o;
        for (int i = 5; i >= 0; i--) cycle(a[4*i +: 4], s, o);
    endtask

    task automatic write_bytes(input logic [23:0] a, input int n, input logic [31:0] d);
        logic [3:0] s;
        logic       o;
        csn_low();
        send_cmd(8'h38);
        send_addr(a);
        for (int i = 0; i < n; i++) begin
            cycle(d[8*i+4 +: 4], s, o);
            cycle(d[8*i +: 4], s, o);
            model[(int'(a[11:0]) + i) % DEPTH] = d[8*i +: 8];
        end
        csn_high();
    endtask

    // Reads n bytes into rd_buf; oe must be low across dummy clocks, high across data
    task automatic read_bytes(input logic [23:0] a, input int n);
        logic [3:0] hi, lo;
        logic       o1, o2;
        logic       oe_bad;
        oe_bad = 1'b0;
        csn_low();
        send_cmd(8'hEB);
        send_addr(a);
        for (int i = 0; i < DUMMY; i++) begin
            cycle(4'h0, hi, o1);
            if (o1) oe_bad = 1'b1;
        end
        for (int i = 0; i < n; i++) begin
            cycle(4'h0, hi, o1);
            cycle(4'h0, lo, o2);
            if (!o1 || !o2) oe_bad = 1'b1;
            rd_buf[i] = {hi, lo};
        end
        csn_high();
        check("read_oe_window", {31'd0, oe_bad}, 32'd0);
        check("oe_after_deselect", {31'd0, ram_io_oe}, 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  s;
        logic        o;
        logic        oe_bad;
        logic [23:0] a, ra;
        logic [31:0] d;
        int          n, off, idx;

        vecs[0] = '{1'b1, 24'h000010, 2, 32'h0000_3CA5};
        vecs[1] = '{1'b0, 24'h000010, 2, 32'h0000_3CA5};
        vecs[2] = '{1'b1, 24'h000FFF, 2, 32'h0000_2211};
        vecs[3] = '{1'b0, 24'h000FFF, 2, 32'h0000_2211};
        vecs[4] = '{1'b0, 24'h000000, 1, 32'h0000_0022};
        vecs[5] = '{1'b1, 24'h000020, 1, 32'h0000_005A};

        #52;
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        #100;
        check("reset_io_o", {28'd0, ram_io_o}, 32'd0);
        check("reset_oe", {31'd0, ram_io_oe}, 32'd0);
        check("reset_busy_after", {31'd0, busy}, 32'd0);

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].wr) begin
                write_bytes(vecs[v].addr, vecs[v].len, vecs[v].bytes);
            end else begin
                read_bytes(vecs[v].addr, vecs[v].len);
                for (int i = 0; i < vecs[v].len; i++)
                    check($sformatf("vec%0d_byte%0d", v, i), {24'd0, rd_buf[i]},
                          {24'd0, vecs[v].bytes[8*i +: 8]});
            end
        end

        // Unknown command: responder must stay silent and leave the store alone
        oe_bad = 1'b0;
        csn_low();
        send_cmd(8'h9F);
        for (int i = 0; i < 10; i++) begin
            cycle(4'($urandom), s, o);
            if (o) oe_bad = 1'b1;
        end
        check("ignore_busy", {31'd0, busy}, 32'd1);
        csn_high();
        check("ignore_oe", {31'd0, oe_bad}, 32'd0);
        read_bytes(24'h000010, 1);
        check("ignore_store_kept", {24'd0, rd_buf[0]}, 32'hA5);

        // Partial write: one nibble then deselect
        csn_low();
        send_cmd(8'h38);
        send_addr(24'h000020);
        cycle(4'h7, s, o);
        #(HALF);
        check("partial_busy_before", {31'd0, busy}, 32'd1);
        ram_csn = 1'b1;
        #30;
        check("partial_busy_drop", {31'd0, busy}, 32'd0);
        #200;
        read_bytes(24'h000020, 1);
        check("partial_discarded", {24'd0, rd_buf[0]}, 32'h5A);

        // Reset in the middle of a read burst
        csn_low();
        send_cmd(8'hEB);
        send_addr(24'h000010);
        for (int i = 0; i < DUMMY + 1; i++) cycle(4'h0, s, o);
        #40;
        check("pre_reset_oe", {31'd0, ram_io_oe}, 32'd1);
        check("pre_reset_io", {28'd0, ram_io_o}, 32'h5);
        reset = 1'b1;
        #1;
        check("reset_mid_oe", {31'd0, ram_io_oe}, 32'd0);
        check("reset_mid_io", {28'd0, ram_io_o}, 32'd0);
        check("reset_mid_busy", {31'd0, busy}, 32'd0);
        ram_csn = 1'b1;
        #109;
        reset = 1'b0;
        #100;
        read_bytes(24'h000010, 2);
        check("post_reset_b0", {24'd0, rd_buf[0]}, 32'hA5);
        check("post_reset_b1", {24'd0, rd_buf[1]}, 32'h3C);

        // Random bursts against the byte-array model; upper bus address bits are don't-care
        for (int t = 0; t < 14; t++) begin
            a = {12'($urandom), 12'($urandom_range(0, DEPTH-1))};
            if (t % 4 == 0) a[11:0] = 12'hFFE;
            n = $urandom_range(1, 4);
            d = $urandom;
            write_bytes(a, n, d);
            off = $urandom_range(0, n-1);
            ra = {12'($urandom), 12'(a[11:0] + 12'(off))};
            read_bytes(ra, n - off);
            for (int j = 0; j < n - off; j++) begin
                idx = (int'(ra[11:0]) + j) % DEPTH;
                check($sformatf("rand%0d_byte%0d", t, j), {24'd0, rd_buf[j]}, {24'd0, model[idx]});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
